// File: rtl/atpg_pair_sequencer_if.sv
// Bus between the ATPG pair sequencer and whatever loads patterns, starts runs
// and provides the device response.
interface atpg_pair_sequencer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 1,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [IN_W-1:0]  load_v1;
    logic [IN_W-1:0]  load_v2;
    logic [OUT_W-1:0] load_exp;
    logic [OUT_W-1:0] load_mask;
    logic [AW:0]      num_patterns;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic [AW-1:0]    res_idx;
    logic [OUT_W-1:0] res_data;
    logic             res_fail;
    logic [15:0]      fail_count;

    modport master (
        output load_en, load_addr, load_v1, load_v2, load_exp, load_mask,
        output num_patterns, start, abort, dut_out,
        input  dut_in, busy, done, res_valid, res_idx, res_data, res_fail, fail_count
    );

    modport slave (
        input  load_en, load_addr, load_v1, load_v2, load_exp, load_mask,
        input  num_patterns, start, abort, dut_out,
        output dut_in, busy, done, res_valid, res_idx, res_data, res_fail, fail_count
    );
endinterface

// File: rtl/atpg_pair_sequencer.sv
// Applies stored two-vector (init/launch) test pairs to a device, captures and
// compares each response, and counts masked mismatches.
module atpg_pair_sequencer #(
    parameter int IN_W   = 4,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 8,
    parameter int HOLD   = 4,
    parameter int SETTLE = 1
) (
    input logic clk,
    input logic rst,
    atpg_pair_sequencer_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (HOLD > SETTLE) ? HOLD : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_END   = CW'(HOLD - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, INIT, LAUNCH, CAPTURE, DONE} state_t;

    logic [IN_W-1:0]  v1_mem   [DEPTH];
    logic [IN_W-1:0]  v2_mem   [DEPTH];
    logic [OUT_W-1:0] exp_mem  [DEPTH];
    logic [OUT_W-1:0] mask_mem [DEPTH];

    state_t        state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [AW-1:0] last_idx, last_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW:0]   num_eff;
    logic          cap;
    logic          miss;

    function automatic logic masked_miss(input logic [OUT_W-1:0] resp,
                                         input logic [OUT_W-1:0] expv,
                                         input logic [OUT_W-1:0] mask);
        return |((resp ^ expv) & ~mask);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [IN_W-1:0] drive_vec(input state_t s, input logic [AW-1:0] i);
        case (s)
            INIT:            return v1_mem[i];
            LAUNCH, CAPTURE: return v2_mem[i];
            default:         return '0;
        endcase
    endfunction

    // Pattern memory is deliberately outside reset so patterns survive rst.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && bus.load_en) begin
            v1_mem[bus.load_addr]   <= bus.load_v1;
            v2_mem[bus.load_addr]   <= bus.load_v2;
            exp_mem[bus.load_addr]  <= bus.load_exp;
            mask_mem[bus.load_addr] <= bus.load_mask;
        end
    end

    assign num_eff = (bus.num_patterns > DEPTH_L) ? DEPTH_L : bus.num_patterns;
    assign cap     = (state == CAPTURE) && !bus.abort;
    assign miss    = masked_miss(bus.dut_out, exp_mem[idx], mask_mem[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            last_idx <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            last_idx <= last_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last_idx;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    idx_n = '0;
                    cnt_n = '0;
                    if (num_eff == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = INIT;
                        last_n  = AW'(num_eff - 1'b1);
                    end
                end
            end
            INIT: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (cnt == HOLD_END) begin
                    cnt_n   = '0;
                    state_n = LAUNCH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LAUNCH: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (cnt == SETTLE_END) begin
                    cnt_n   = '0;
                    state_n = CAPTURE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (idx == last_idx) begin
                    state_n = DONE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = INIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so dut_in lines up with the state
    // it belongs to; done fires the cycle after DONE so it never overlaps the
    // final result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.dut_in     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_idx    <= '0;
            bus.res_data   <= '0;
            bus.res_fail   <= 1'b0;
            bus.fail_count <= '0;
        end else begin
            bus.dut_in    <= drive_vec(state_n, idx_n);
            bus.busy      <= (state_n == INIT) || (state_n == LAUNCH) || (state_n == CAPTURE);
            bus.done      <= (state == DONE);
            bus.res_valid <= cap;
            bus.res_fail  <= cap && miss;
            if (cap) begin
                bus.res_idx  <= idx;
                bus.res_data <= bus.dut_out;
            end
            if (state == IDLE && bus.start) begin
                bus.fail_count <= '0;
            end else if (cap && miss) begin
                bus.fail_count <= sat_inc(bus.fail_count);
            end
        end
    end
endmodule

// File: tb/tb_atpg_pair_sequencer.sv
// Scoreboard bench for atpg_pair_sequencer: directed runs push expected results,
// a negedge monitor pops and compares whatever the sequencer reports.
module tb_atpg_pair_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic resp_force = 1'b0;

    typedef struct { int idx; int data; int fail; int fc; int cyc; } res_t;
    typedef struct { int fc; int cyc; } done_t;
    res_t  res_q[$];
    done_t done_q[$];

    logic [3:0] m_v1[8];
    logic [3:0] m_v2[8];
    logic       m_exp[8];
    logic       m_mask[8];

    atpg_pair_sequencer_if #(.IN_W(4), .OUT_W(1), .DEPTH(8)) bus ();

    atpg_pair_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(8), .HOLD(4), .SETTLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.dut_out = resp_force ? 1'b1 : (bus.dut_in[3] & bus.dut_in[2]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid) begin
                if (res_q.size() == 0) begin
                    chk("spurious_res_valid", bus.res_valid, 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res_idx", bus.res_idx, r.idx);
                    chk("res_data", bus.res_data, r.data);
                    chk("res_fail", bus.res_fail, r.fail);
                    chk("res_fail_count", bus.fail_count, r.fc);
                    chk("res_cycle", cyc, r.cyc);
                end
            end
            if (bus.done) begin
                chk("done_excl_res", bus.res_valid, 0);
                if (done_q.size() == 0) begin
                    chk("spurious_done", bus.done, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_fail_count", bus.fail_count, d.fc);
                    chk("done_cycle", cyc, d.cyc);
                end
            end
        end
    end

    task automatic load(input int a, input logic [3:0] v1, input logic [3:0] v2,
                        input logic e, input logic m);
        @(negedge clk);
        bus.load_en = 1'b1; bus.load_addr = 3'(a);
        bus.load_v1 = v1; bus.load_v2 = v2; bus.load_exp = e; bus.load_mask = m;
        m_v1[a] = v1; m_v2[a] = v2; m_exp[a] = e; m_mask[a] = m;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after start was sampled.
    task automatic run(input int n, input bit with_abort, output int k);
        @(negedge clk);
        bus.start = 1'b1; bus.abort = with_abort; bus.num_patterns = 4'(n);
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        k = cyc;
    endtask

    // Model: pushes the first 'keep' results of an n-pattern run started at k.
    task automatic expect_run(input int k, input int n, input int keep);
        int eff, fc;
        eff = (n > 8) ? 8 : n;
        fc = 0;
        for (int i = 0; i < eff && i < keep; i++) begin
            res_t r;
            r.data = resp_force ? 1 : int'(m_v2[i][3] & m_v2[i][2]);
            r.fail = int'((r.data[0] ^ m_exp[i]) & ~m_mask[i]);
            fc += r.fail;
            r.idx = i; r.fc = fc; r.cyc = k + 6 * (i + 1);
            res_q.push_back(r);
        end
        if (keep >= eff) begin
            done_t d;
            d.fc = fc; d.cyc = k + 6 * eff + 1;
            done_q.push_back(d);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((res_q.size() != 0 || done_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_res_drained"}, res_q.size(), 0);
        chk({name, "_done_drained"}, done_q.size(), 0);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_dut_in"}, bus.dut_in, 0);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_done"}, bus.done, 0);
        chk({name, "_res_valid"}, bus.res_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [3:0] v1s[6] = '{4'b0001, 4'b0010, 4'b0001, 4'b1110, 4'b1001, 4'b0101};
        logic [3:0] v2s[6] = '{4'b1001, 4'b1110, 4'b0101, 4'b0001, 4'b0000, 4'b1111};

        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_v1 = '0; bus.load_v2 = '0;
        bus.load_exp = '0; bus.load_mask = '0; bus.num_patterns = '0;
        bus.start = 1'b0; bus.abort = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_fail_count", bus.fail_count, 0);
        chk("reset_res_idx", bus.res_idx, 0);
        rst = 1'b0;

        // Single pair with per-cycle stimulus check
        load(0, 4'b0001, 4'b1001, 1'b0, 1'b0);
        run(1, 1'b0, k);
        expect_run(k, 1, 1);
        for (int j = 0; j < 6; j++) begin
            chk("single_dut_in", bus.dut_in, (j < 4) ? 4'b0001 : 4'b1001);
            chk("single_busy", bus.busy, 1);
            @(negedge clk);
        end
        wait_drain("single");
        chk("single_fail_count", bus.fail_count, 0);

        // Six pairs; start and load_en poked mid-run must be ignored
        for (int i = 0; i < 6; i++) load(i, v1s[i], v2s[i], 1'b0, 1'b0);
        run(6, 1'b0, k);
        expect_run(k, 6, 6);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.num_patterns = 4'd1;
        bus.load_en = 1'b1; bus.load_addr = 3'd3; bus.load_v2 = 4'b1111;
        @(negedge clk);
        bus.start = 1'b0; bus.load_en = 1'b0;
        wait_drain("six");
        chk("six_fail_count", bus.fail_count, 2);

        // num_patterns = 0 together with abort: start wins, done only
        run(0, 1'b1, k);
        expect_run(k, 0, 0);
        wait_drain("zero");
        chk("zero_fail_count", bus.fail_count, 0);

        // num_patterns beyond DEPTH runs all eight entries
        load(6, 4'b0011, 4'b1100, 1'b0, 1'b0);
        load(7, 4'b0000, 4'b0100, 1'b0, 1'b0);
        run(12, 1'b0, k);
        expect_run(k, 12, 12);
        wait_drain("clamp");
        chk("clamp_fail_count", bus.fail_count, 3);

        // Abort in LAUNCH of pattern 2
        run(6, 1'b0, k);
        expect_run(k, 6, 2);
        repeat (16) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle_outputs("abort");
        repeat (20) @(negedge clk);
        chk("abort_fail_count_frozen", bus.fail_count, 1);
        wait_drain("abort");

        // Reset mid-run, then identical rerun
        run(6, 1'b0, k);
        expect_run(k, 6, 1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle_outputs("midrst");
        chk("midrst_fail_count", bus.fail_count, 0);
        wait_drain("midrst");
        run(6, 1'b0, k);
        expect_run(k, 6, 6);
        wait_drain("rerun");
        chk("rerun_fail_count", bus.fail_count, 2);

        // Forced response 1: masked entry passes, unmasked entry fails
        load(0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        load(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        resp_force = 1'b1;
        run(2, 1'b0, k);
        expect_run(k, 2, 2);
        wait_drain("masked");
        chk("masked_fail_count", bus.fail_count, 1);
        resp_force = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/atpg_pair_sequencer.md
ATPG_PAIR_SEQUENCER -- requirements
Module: atpg_pair_sequencer

Interface
REQ-001 The block SHALL have parameter IN_W, default 4, meaning width of the vector driven into the device under test.
REQ-002 The block SHALL have parameter OUT_W, default 1, meaning width of the captured device response.
REQ-003 The block SHALL have parameter DEPTH, default 8, meaning number of stored pattern pairs (power of 2, >=2); AW = log2(DEPTH).
REQ-004 The block SHALL have parameter HOLD, default 4, meaning cycles the initialisation vector is held (>=1).
REQ-005 The block SHALL have parameter SETTLE, default 1, meaning cycles the launch vector is held before capture (>=1).
REQ-006 The block SHALL have one clock; reset is synchronous and active-high; ports are clk (in, 1) and rst (in, 1).
REQ-007 The block SHALL have these ports:
- load_en, in, 1: write pattern entry.
- load_addr, in, AW: entry index.
- load_v1, in, IN_W: initialisation vector.
- load_v2, in, IN_W: launch vector.
- load_exp, in, OUT_W: expected response.
- load_mask, in, OUT_W: 1 = don't-care bit.
- num_patterns, in, AW+1: patterns to run (0..DEPTH), sampled at start.
- start, in, 1: begin run.
- abort, in, 1: cancel run.
- dut_in, out, IN_W: stimulus to device.
- dut_out, in, OUT_W: device response.
- busy, out, 1: run in progress.
- done, out, 1: one-cycle run-complete pulse.
- res_valid, out, 1: one-cycle result pulse.
- res_idx, out, AW: pattern index of result.
- res_data, out, OUT_W: captured response.
- res_fail, out, 1: masked mismatch.
- fail_count, out, 16: saturating mismatch count for current/last run.

Function
REQ-008 Pattern memory SHALL be written on a rising edge with load_en=1 only in IDLE; load_en in any other state SHALL be ignored.
REQ-009 FSM states SHALL be IDLE, INIT, LAUNCH, CAPTURE, DONE; all outputs registered.
REQ-010 IDLE: dut_in=0, busy=0; start=1 with num_patterns in 1..DEPTH SHALL go to INIT with idx=0, fail_count=0, num_patterns latched.
REQ-011 start=1 with num_patterns=0 SHALL go to DONE (done pulse, fail_count=0, no res_valid); num_patterns>DEPTH SHALL be treated as DEPTH.
REQ-012 INIT: dut_in=v1[idx] for exactly HOLD cycles, then LAUNCH.
REQ-013 LAUNCH: dut_in=v2[idx] for exactly SETTLE cycles, then CAPTURE.
REQ-014 CAPTURE: one cycle, dut_in=v2[idx]; dut_out sampled at the edge ending CAPTURE.
REQ-015 On that edge: res_valid=1, res_idx=idx, res_data=dut_out, res_fail=|((dut_out^exp[idx]) & ~mask[idx]).
REQ-016 Results SHALL be valid for exactly one cycle.
REQ-017 res_fail=1 SHALL increment fail_count, saturating at 16'hFFFF.
REQ-018 After CAPTURE: idx==latched count-1 -> DONE, else idx+1 -> INIT.
REQ-019 Each pattern SHALL take HOLD+SETTLE+1 cycles, with no gap between patterns.
REQ-020 DONE: one cycle, done=1, dut_in=0, busy=0, then IDLE.
REQ-021 fail_count SHALL hold its value until the next accepted start.
REQ-022 busy SHALL be 1 in INIT, LAUNCH and CAPTURE.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort=1 in INIT/LAUNCH/CAPTURE SHALL return to IDLE next cycle: no done, no res_valid, fail_count frozen.
REQ-025 abort and start together in IDLE: start SHALL win.
REQ-026 res_valid and done SHALL never assert in the same cycle.

Reset
REQ-027 rst=1 SHALL force IDLE and set dut_in=0, busy=0, done=0, res_valid=0, res_idx=0, res_data=0, res_fail=0, fail_count=0, idx=0.
REQ-028 rst SHALL override start, abort and load_en, including mid-run.
REQ-029 Pattern memory contents SHALL NOT be altered by rst.

Verification
REQ-030 Single pair (defaults, dut_out=AND of dut_in[3:2]):
- v1=0001, v2=1001, exp=0, mask=0, num=1, start.
- dut_in=0001 for 4 cycles, then 1001 for 2 cycles.
- res_valid with res_data=0, res_fail=0; done next cycle; fail_count=0.
REQ-031 Six pairs (v1/v2: 0001/1001, 0010/1110, 0001/0101, 1110/0001, 1001/0000, 0101/1111), all exp=0:
- res_idx 0..5 every 6 cycles.
- res_fail only for idx 1 and 5; fail_count=2.
REQ-032 Masked mismatch: exp=0, mask=1, response 1 -> res_fail=0, fail_count unchanged.
REQ-033 Control edge cases:
- num_patterns=0 -> done one cycle after start, no res_valid.
- start while busy -> no effect on sequence timing.
REQ-034 Abort and reset mid-run:
- abort in LAUNCH of pattern 2 -> IDLE next cycle, no done, fail_count frozen.
- rst mid-run -> all outputs 0 next cycle; rerun with same patterns gives identical results.
